// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and framing constants for the boot loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_word_pack.sv
// loader_word_pack: packs payload bytes MSB-first into 32-bit words.
// Latency: word/word_valid are combinational on the 4th byte; the earlier 3 bytes are registered.
// Backpressure: none of its own; it shifts only when the parent asserts take.
module loader_word_pack
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  // Only the three earlier bytes need storage; the 4th is the byte on the bus.
  logic [23:0] sr;
  logic [1:0]  cnt;

  assign word       = {sr, in_byte};
  assign word_valid = take && (cnt == LAST_BYTE);

  // Shift register and byte position; cleared at the start of every session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (take) begin
      sr  <= word[23:0];
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: fills program memory from a byte stream (2-byte count header, big-endian words), then releases the core.
// Latency: write strobe in the cycle after a word's 4th byte; 5 cycles/word at full rate. Optional LOADER_CHECKSUM_EN adds a trailing sum byte.
// Backpressure: in_ready only in HDR/LOAD/CSUM, low during the write cycle; waits forever on in_valid.
module prog_loader #(
  parameter int MEM_BYTES = 4096,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_inst,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        error
);
  import prog_loader_pkg::*;

  localparam int               WORDS    = MEM_BYTES / BYTES_PER_WORD;
  localparam int               IDX_W    = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0] N_MAX    = CNT_W'(WORDS);
  localparam logic             HDR_LAST = 1'(HDR_BYTES - 1);

  state_t           state, nxt;
  logic             hdr_cnt;
  logic [CNT_W-9:0] n_hi;
  logic [CNT_W-1:0] n_full, n_words;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             hdr_entry, hdr_done, take, last_word, word_valid;
  logic [31:0]      word;

  assign n_full    = {n_hi, in_data};
  assign hdr_done  = (state == HDR) && in_valid && (hdr_cnt == HDR_LAST);
  assign take      = (state == LOAD) && in_valid;
  assign idx_nxt   = idx + 1'b1;
  assign last_word = (CNT_W'(idx_nxt) == n_words);
  // A start accepted from IDLE/DONE/ERR opens a fresh session.
  assign hdr_entry = (state != HDR) && (nxt == HDR);

  loader_word_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (hdr_entry),
    .take       (take),
    .in_byte    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;

  // Running 8-bit sum of payload bytes only; header bytes never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sum <= '0;
    else if (hdr_entry) sum <= '0;
    else if (take)      sum <= sum + in_data;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state selection and state-decoded outputs.
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    mem_write = 1'b0;
    cpu_run   = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = HDR;
      HDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hdr_done) begin
          if (n_full == '0)        nxt = DONE;
          else if (n_full > N_MAX) nxt = ERR;
          else                     nxt = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_valid) nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          nxt = CSUM;
`else
          nxt = DONE;
`endif
        end else begin
          nxt = LOAD;
        end
      end
      CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (in_valid) nxt = (in_data == sum) ? DONE : ERR;
`endif
      end
      DONE: begin
        cpu_run = 1'b1;
        done    = 1'b1;
        if (start) nxt = HDR;
      end
      ERR: begin
        error = 1'b1;
        if (start) nxt = HDR;
      end
      default: nxt = IDLE;
    endcase
  end

  // Header capture: shift in count bytes MSB-first, latch the full count on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt <= 1'b0;
      n_hi    <= '0;
      n_words <= '0;
    end else if (hdr_entry) begin
      hdr_cnt <= 1'b0;
      n_hi    <= '0;
    end else if ((state == HDR) && in_valid) begin
      hdr_cnt <= hdr_cnt + 1'b1;
      n_hi    <= n_full[CNT_W-9:0];
      if (hdr_done) n_words <= n_full;
    end
  end

  // Word index advances at the end of each write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              idx <= '0;
    else if (hdr_entry)      idx <= '0;
    else if (state == WRITE) idx <= idx_nxt;
  end

  // Write address/data registered on the 4th byte so they are valid throughout WRITE and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= '0;
      mem_inst    <= '0;
    end else if (word_valid) begin
      mem_address <= 32'({idx, 2'b00});
      mem_inst    <= word;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader against a byte-stream reference model.
// Latency: checks header-to-cpu_run timing at 5 cycles per word under continuous in_valid.
// Backpressure: drives in_valid continuous, toggled and randomly gapped; honours in_ready.
module tb_prog_loader;

  localparam int LIMIT = 4096 / 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_write, cpu_run, busy, done, error;
  logic [31:0] mem_address, mem_inst;

  prog_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_inst    (mem_inst),
    .cpu_run     (cpu_run),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc_edge = 0;
  int hdr_edge = 0;
  int end_cyc = 0;
  int wr_pulses = 0;
  bit multi_wr = 0;
  bit rdy_in_write = 0;
  bit prev_wr = 0;
  bit rdy_after_start = 0;
  bit err_after_start = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  pay[$];

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Program-memory model and write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_write) begin
      mem[mem_address[11:2]] = mem_inst;
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_inst);
      wr_pulses++;
      if (prev_wr) multi_wr = 1;
      if (in_ready) rdy_in_write = 1;
    end
    prev_wr = mem_write;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_word(input int i);
    return {pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
  endfunction

  function automatic int model_writes(input int n);
    return (n >= 1 && n <= LIMIT) ? n : 0;
  endfunction

  // {done, error} at the end of a session
  function automatic logic [1:0] model_end(input int n, input bit csum_good);
    if (n == 0)                            return 2'b10;
    if (n > LIMIT)                         return 2'b01;
    if (CSUM_ON && !csum_good)             return 2'b01;
    return 2'b10;
  endfunction

  function automatic int gapv(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      ok       = in_ready;
      if (ok) last_acc_edge = cyc + 1;
      @(posedge clk);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte_timeout: in_ready stayed 0 for byte %02h, required 1", b);
    end
  endtask

  task automatic run_session(input int n, input int gap_mode, input bit csum_good);
    logic [15:0] hdr;
    logic [7:0]  s;
    hdr = 16'(n);
    wr_addr.delete();
    wr_data.delete();
    wr_pulses = 0;
    multi_wr = 0;
    rdy_in_write = 0;
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rdy_after_start = in_ready;
    err_after_start = error;
    send_byte(hdr[15:8], gapv(gap_mode));
    send_byte(hdr[7:0], gapv(gap_mode));
    hdr_edge = last_acc_edge;
    if (model_writes(n) > 0) begin
      s = '0;
      for (int i = 0; i < 4 * n; i++) begin
        send_byte(pay[i], gapv(gap_mode));
        s = s + pay[i];
      end
      if (CSUM_ON) send_byte(csum_good ? s : s + 8'd1, gapv(gap_mode));
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 40 && busy; t++) @(negedge clk);
    end_cyc = cyc;
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL session_end_timeout: busy still 1 after 40 cycles, required 0");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, mem_write, busy, done, error, cpu_run} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 000000", {in_ready, mem_write, busy, done, error, cpu_run});
    end
    vectors++;
    if (mem_address !== 32'h0 || mem_inst !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: addr %h inst %h, required 0/0", mem_address, mem_inst);
    end
    in_valid = 1'b1;
    in_data = 8'($urandom);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if ({in_ready, busy, mem_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset: rdy/busy/wr %b, required 000", {in_ready, busy, mem_write});
    end
  endtask

  task automatic test_two_words();
    pay = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    run_session(2, 0, 1'b1);
    vectors++;
    if (rdy_after_start !== 1'b1) begin
      miscompares++;
      $display("FAIL entry_ready: in_ready %b after start, required 1", rdy_after_start);
    end
    vectors++;
    if (wr_pulses !== 2 || multi_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL two_pulses: pulses %0d multi %b, required 2 / 0", wr_pulses, multi_wr);
    end
    vectors++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h20080005
        || wr_addr[1] !== 32'h4 || wr_data[1] !== 32'hAC080000) begin
      miscompares++;
      $display("FAIL two_words_data: %0d writes, required 0:20080005 4:AC080000", wr_addr.size());
    end
    vectors++;
    if (mem[0] !== 32'h20080005 || mem[1] !== 32'hAC080000) begin
      miscompares++;
      $display("FAIL two_words_mem: %h %h, required 20080005 AC080000", mem[0], mem[1]);
    end
    vectors++;
    if (end_cyc !== hdr_edge + 5 * 2) begin
      miscompares++;
      $display("FAIL run_timing: cpu_run after %0d cycles, required %0d", end_cyc - hdr_edge, 10);
    end
    vectors++;
    if ({cpu_run, done, error} !== 3'b110) begin
      miscompares++;
      $display("FAIL two_words_end: run/done/err %b, required 110", {cpu_run, done, error});
    end
  endtask

  task automatic test_zero_hdr();
    pay.delete();
    run_session(0, 0, 1'b1);
    vectors++;
    if (wr_pulses !== 0 || {cpu_run, done, error} !== 3'b110) begin
      miscompares++;
      $display("FAIL zero_hdr: pulses %0d run/done/err %b, required 0 / 110", wr_pulses, {cpu_run, done, error});
    end
  endtask

  task automatic test_oversize();
    pay.delete();
    run_session(16'h0401, 0, 1'b1);
    vectors++;
    if (wr_pulses !== 0 || {cpu_run, done, error} !== 3'b001) begin
      miscompares++;
      $display("FAIL oversize: pulses %0d run/done/err %b, required 0 / 001", wr_pulses, {cpu_run, done, error});
    end
    run_session(0, 0, 1'b1);
    vectors++;
    if (err_after_start !== 1'b0 || error !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL error_clear: err after start %b, end err %b done %b, required 0/0/1", err_after_start, error, done);
    end
  endtask

  task automatic test_throttle();
    pay.delete();
    for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
    run_session(3, 1, 1'b1);
    vectors++;
    if (wr_addr.size() != 3) begin
      miscompares++;
      $display("FAIL throttle_count: %0d writes, required 3", wr_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
      vectors++;
      if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== model_word(i)) begin
        miscompares++;
        $display("FAIL throttle_word%0d: %h:%h, required %h:%h", i, wr_addr[i], wr_data[i], 32'(4 * i), model_word(i));
      end
    end
    vectors++;
    if (rdy_in_write !== 1'b0 || multi_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL write_ready: in_ready-in-write %b multi %b, required 0/0", rdy_in_write, multi_wr);
    end
  endtask

  task automatic test_reset_midload();
    pay.delete();
    for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
    wr_addr.delete();
    wr_data.delete();
    wr_pulses = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 6; i++) send_byte(pay[i], 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, mem_write, busy, done, error, cpu_run} !== 6'b0 || mem_address !== 32'h0 || mem_inst !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: flags %b addr %h inst %h, required all 0",
               {in_ready, mem_write, busy, done, error, cpu_run}, mem_address, mem_inst);
    end
    vectors++;
    if (wr_pulses !== 1 || mem[0] !== model_word(0)) begin
      miscompares++;
      $display("FAIL kept_word0: pulses %0d mem0 %h, required 1 / %h", wr_pulses, mem[0], model_word(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(8'($urandom));
    run_session(1, 0, 1'b1);
    vectors++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== model_word(0) || done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart: %0d writes, first addr %h data %h done %b, required 1 write 0:%h done 1",
               wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'hx, (wr_data.size() > 0) ? wr_data[0] : 32'hx,
               done, model_word(0));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      int  n;
      int  r;
      int  nw;
      bit  good;
      logic [1:0] ex;
      r = int'($urandom_range(0, 9));
      n = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(1025, 65535)) : int'($urandom_range(1, 4));
      good = ($urandom_range(0, 3) != 0);
      nw = model_writes(n);
      ex = model_end(n, good);
      pay.delete();
      for (int i = 0; i < 4 * nw; i++) pay.push_back(8'($urandom));
      run_session(n, 2, good);
      vectors++;
      if ({done, error, cpu_run} !== {ex, ex[1]}) begin
        miscompares++;
        $display("FAIL rand%0d_end: n=%0d done/err/run %b, required %b", k, n, {done, error, cpu_run}, {ex, ex[1]});
      end
      vectors++;
      if (wr_addr.size() != nw) begin
        miscompares++;
        $display("FAIL rand%0d_count: n=%0d %0d writes, required %0d", k, n, wr_addr.size(), nw);
      end
      for (int i = 0; i < wr_addr.size() && i < nw; i++) begin
        vectors++;
        if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== model_word(i) || mem[i] !== model_word(i)) begin
          miscompares++;
          $display("FAIL rand%0d_word%0d: %h:%h mem %h, required %h:%h", k, i, wr_addr[i], wr_data[i], mem[i],
                   32'(4 * i), model_word(i));
        end
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(1, 0, 1'b1);
    vectors++;
    if ({done, error, cpu_run} !== 3'b101 || wr_pulses !== 1) begin
      miscompares++;
      $display("FAIL csum_good: done/err/run %b pulses %0d, required 101 / 1", {done, error, cpu_run}, wr_pulses);
    end
    run_session(1, 0, 1'b0);
    vectors++;
    if ({done, error, cpu_run} !== 3'b010 || mem[0] !== 32'h01020304) begin
      miscompares++;
      $display("FAIL csum_bad: done/err/run %b mem0 %h, required 010 / 01020304", {done, error, cpu_run}, mem[0]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;
    test_reset();
    test_two_words();
    test_zero_hdr();
    test_oversize();
    test_throttle();
    test_reset_midload();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
